// File: rtl/shift_operand_if.sv
// shift_operand_if: upstream operand offer and downstream shifter command bundle.
interface shift_operand_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] rm_val;
  logic [31:0] rs_val;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  funct;
  logic [31:0] a;
  logic [4:0]  N;
  logic        out_err;
  modport slave (
    input  in_valid, instr, rm_val, rs_val, out_ready,
    output in_ready, out_valid, funct, a, N, out_err
  );
  modport master (
    output in_valid, instr, rm_val, rs_val, out_ready,
    input  in_ready, out_valid, funct, a, N, out_err
  );
endinterface

// File: rtl/shift_operand_stage.sv
// shift_operand_stage: decodes the operand-2 shift field into barrel-shifter funct/a/N, registered valid/ready stage.
module shift_operand_stage #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  shift_operand_if.slave   bus,
  output logic [CNT_W-1:0] cnt_ok,
  output logic [CNT_W-1:0] cnt_err
);
  logic             out_valid_q, out_valid_d;
  logic [1:0]       funct_q, funct_d;
  logic [31:0]      a_q, a_d;
  logic [4:0]       n_q, n_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_ok_q, cnt_ok_d, cnt_err_q, cnt_err_d;
  logic [7:0]       amt;
  logic [1:0]       sh;
  logic             pass, sat, dec_err, special, load, fire;
  logic [1:0]       dec_funct;
  logic [31:0]      dec_a;
  logic [4:0]       dec_n;
  logic             unused_bits;
  assign unused_bits  = ^{bus.instr[31:12], bus.instr[3:0], bus.rs_val[31:8]};
  assign bus.in_ready = !out_valid_q || bus.out_ready;
  always_comb begin
    sh = bus.instr[6:5];
    amt = bus.instr[4] ? bus.rs_val[7:0] : {3'b0, bus.instr[11:7]};
    pass = bus.instr[4] && amt == 8'd0;
    // sat covers every shift of 32 or more: imm5=0 on LSR/ASR/ROR, or a register amount >= 32
    sat = bus.instr[4] ? |amt[7:5] : (amt == 8'd0 && sh != 2'b00);
    dec_err = sh == 2'b11 && !pass;
    special = pass || sat || dec_err;
    dec_funct = special ? 2'b01 : sh == 2'b00 ? 2'b00 : sh == 2'b01 ? 2'b10 : 2'b11;
    dec_a = (pass || dec_err || !sat) ? bus.rm_val : sh == 2'b10 ? {32{bus.rm_val[31]}} : 32'd0;
    dec_n = special ? 5'd0 : amt[4:0];
    fire = out_valid_q && bus.out_ready;
    load = bus.in_valid && bus.in_ready;
    out_valid_d = load ? 1'b1 : fire ? 1'b0 : out_valid_q;
    funct_d = load ? dec_funct : funct_q;
    a_d = load ? dec_a : a_q;
    n_d = load ? dec_n : n_q;
    err_d = load ? dec_err : err_q;
    cnt_ok_d = (fire && !err_q && !(&cnt_ok_q)) ? cnt_ok_q + CNT_W'(1) : cnt_ok_q;
    cnt_err_d = (fire && err_q && !(&cnt_err_q)) ? cnt_err_q + CNT_W'(1) : cnt_err_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      funct_q     <= 2'b01;
      a_q         <= '0;
      n_q         <= '0;
      err_q       <= 1'b0;
      cnt_ok_q    <= '0;
      cnt_err_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      funct_q     <= funct_d;
      a_q         <= a_d;
      n_q         <= n_d;
      err_q       <= err_d;
      cnt_ok_q    <= cnt_ok_d;
      cnt_err_q   <= cnt_err_d;
    end
  end
  assign bus.out_valid = out_valid_q;
  assign bus.funct     = funct_q;
  assign bus.a         = a_q;
  assign bus.N         = n_q;
  assign bus.out_err   = err_q;
  assign cnt_ok        = cnt_ok_q;
  assign cnt_err       = cnt_err_q;
endmodule

// File: tb/tb_shift_operand_stage.sv
// tb_shift_operand_stage: directed checks of decode, handshake, counters and reset for shift_operand_stage.
module tb_shift_operand_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [15:0] cnt_ok, cnt_err;
  logic [2:0]  cnt_ok2, cnt_err2;
  int checks = 0;
  int errors = 0;
  int exp_ok = 0;
  int exp_err = 0;

  shift_operand_if bus ();
  shift_operand_if bus2 ();

  shift_operand_stage #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .cnt_ok(cnt_ok), .cnt_err(cnt_err)
  );
  shift_operand_stage #(.CNT_W(3)) dut_small (
    .clk(clk), .rst_n(rst_n), .bus(bus2), .cnt_ok(cnt_ok2), .cnt_err(cnt_err2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] rm;
    logic [31:0] rs;
    logic [1:0]  f;
    logic [31:0] a;
    logic [4:0]  n;
    logic        e;
  } vec_t;

  function automatic logic [31:0] mk(input logic [4:0] imm5, input logic [1:0] sh, input logic r);
    return {20'd0, imm5, sh, r, 4'd0};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b1;
    bus.instr = mk(5'd4, 2'b00, 1'b0);
    bus.rm_val = 32'h1234;
    bus.rs_val = 32'd0;
    bus.out_ready = 1'b0;
    step();
    step();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.funct !== 2'b01 || bus.a !== 32'd0 || bus.N !== 5'd0 || bus.out_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b f=%b a=%h N=%0d e=%b, want v=0 f=01 a=0 N=0 e=0",
               bus.out_valid, bus.funct, bus.a, bus.N, bus.out_err);
    end
    checks++;
    if (cnt_ok !== 16'd0 || cnt_err !== 16'd0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_counters: got ok=%0d err=%0d in_ready=%b, want 0 0 1", cnt_ok, cnt_err, bus.in_ready);
    end
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    exp_ok = 0;
    exp_err = 0;
    step();
  endtask

  task automatic test_decode();
    vec_t v[15];
    v = '{
      '{mk(5'd4,  2'b00, 1'b0),                    32'd1012345,   32'd0,     2'b00, 32'd1012345,   5'd4,  1'b0},
      '{mk(5'd0,  2'b01, 1'b0),                    32'h8000_0001, 32'd0,     2'b01, 32'd0,         5'd0,  1'b0},
      '{mk(5'd0,  2'b10, 1'b0),                    32'h8000_0001, 32'd0,     2'b01, 32'hFFFF_FFFF, 5'd0,  1'b0},
      '{mk(5'd7,  2'b01, 1'b0),                    32'hF000_0000, 32'd0,     2'b10, 32'hF000_0000, 5'd7,  1'b0},
      '{mk(5'd31, 2'b10, 1'b0) | 32'hFFFF_F00F,    32'h1234_5678, 32'hFFFF,  2'b11, 32'h1234_5678, 5'd31, 1'b0},
      '{mk(5'd0,  2'b00, 1'b0),                    32'hDEAD_BEEF, 32'd0,     2'b00, 32'hDEAD_BEEF, 5'd0,  1'b0},
      '{mk(5'd0,  2'b10, 1'b1),                    32'h8000_0000, 32'h115,   2'b11, 32'h8000_0000, 5'd21, 1'b0},
      '{mk(5'd0,  2'b01, 1'b1),                    32'h0000_FFFF, 32'h40,    2'b01, 32'd0,         5'd0,  1'b0},
      '{mk(5'd0,  2'b11, 1'b1),                    32'h0000_ABCD, 32'd0,     2'b01, 32'h0000_ABCD, 5'd0,  1'b0},
      '{mk(5'd0,  2'b10, 1'b1),                    32'h8000_0000, 32'h20,    2'b01, 32'hFFFF_FFFF, 5'd0,  1'b0},
      '{mk(5'd0,  2'b00, 1'b1),                    32'd5,         32'h100,   2'b01, 32'd5,         5'd0,  1'b0},
      '{mk(5'd0,  2'b11, 1'b1),                    32'h1234,      32'h40,    2'b01, 32'h1234,      5'd0,  1'b1},
      '{mk(5'd3,  2'b11, 1'b0),                    32'h77,        32'd0,     2'b01, 32'h77,        5'd0,  1'b1},
      '{mk(5'd9,  2'b00, 1'b1),                    32'd3,         32'd1,     2'b00, 32'd3,         5'd1,  1'b0},
      '{mk(5'd0,  2'b01, 1'b1),                    32'h7FFF_FFFF, 32'h1F,    2'b10, 32'h7FFF_FFFF, 5'd31, 1'b0}
    };
    bus.out_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      bus.in_valid = 1'b1;
      bus.instr = v[i].instr;
      bus.rm_val = v[i].rm;
      bus.rs_val = v[i].rs;
      checks++;
      if (bus.in_ready !== 1'b1) begin
        errors++;
        $display("FAIL decode_in_ready[%0d]: got %b want 1", i, bus.in_ready);
      end
      step();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.funct !== v[i].f || bus.a !== v[i].a || bus.N !== v[i].n || bus.out_err !== v[i].e) begin
        errors++;
        $display("FAIL decode[%0d]: got v=%b f=%b a=%h N=%0d e=%b, want v=1 f=%b a=%h N=%0d e=%b",
                 i, bus.out_valid, bus.funct, bus.a, bus.N, bus.out_err, v[i].f, v[i].a, v[i].n, v[i].e);
      end
      if (v[i].e) exp_err++; else exp_ok++;
    end
    bus.in_valid = 1'b0;
    step();
    checks++;
    if (bus.out_valid !== 1'b0 || cnt_ok !== 16'(exp_ok) || cnt_err !== 16'(exp_err)) begin
      errors++;
      $display("FAIL decode_drain: got v=%b ok=%0d err=%0d, want v=0 ok=%0d err=%0d",
               bus.out_valid, cnt_ok, cnt_err, exp_ok, exp_err);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rm_seq [3];
    rm_seq = '{32'h11, 32'h22, 32'h33};
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.instr = mk(5'd1, 2'b00, 1'b0);
    bus.rm_val = rm_seq[0];
    step();
    bus.instr = mk(5'd2, 2'b00, 1'b0);
    bus.rm_val = rm_seq[1];
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.a !== rm_seq[0] || bus.N !== 5'd1) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got in_ready=%b v=%b a=%h N=%0d, want 0 1 %h 1",
                 c, bus.in_ready, bus.out_valid, bus.a, bus.N, rm_seq[0]);
      end
      step();
    end
    checks++;
    if (cnt_ok !== 16'(exp_ok)) begin
      errors++;
      $display("FAIL stall_count: got %0d want %0d", cnt_ok, exp_ok);
    end
    bus.out_ready = 1'b1;
    step();
    exp_ok++;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.a !== rm_seq[1] || bus.N !== 5'd2) begin
      errors++;
      $display("FAIL b2b_second: got v=%b a=%h N=%0d, want 1 %h 2", bus.out_valid, bus.a, bus.N, rm_seq[1]);
    end
    bus.instr = mk(5'd3, 2'b00, 1'b0);
    bus.rm_val = rm_seq[2];
    step();
    exp_ok++;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.a !== rm_seq[2] || bus.N !== 5'd3) begin
      errors++;
      $display("FAIL b2b_third: got v=%b a=%h N=%0d, want 1 %h 3", bus.out_valid, bus.a, bus.N, rm_seq[2]);
    end
    bus.in_valid = 1'b0;
    step();
    exp_ok++;
    checks++;
    if (bus.out_valid !== 1'b0 || cnt_ok !== 16'(exp_ok)) begin
      errors++;
      $display("FAIL b2b_drain: got v=%b ok=%0d, want 0 %0d", bus.out_valid, cnt_ok, exp_ok);
    end
  endtask

  task automatic test_error_counter();
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.instr = mk(5'd3, 2'b11, 1'b0);
    bus.rm_val = 32'hCAFE;
    step();
    bus.in_valid = 1'b0;
    step();
    checks++;
    if (bus.out_err !== 1'b1 || bus.funct !== 2'b01 || bus.a !== 32'hCAFE || cnt_err !== 16'(exp_err)) begin
      errors++;
      $display("FAIL err_held: got e=%b f=%b a=%h cnt_err=%0d, want 1 01 cafe %0d",
               bus.out_err, bus.funct, bus.a, cnt_err, exp_err);
    end
    bus.out_ready = 1'b1;
    step();
    exp_err++;
    checks++;
    if (cnt_err !== 16'(exp_err) || cnt_ok !== 16'(exp_ok) || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL err_count: got err=%0d ok=%0d v=%b, want %0d %0d 0",
               cnt_err, cnt_ok, bus.out_valid, exp_err, exp_ok);
    end
  endtask

  task automatic test_saturation();
    bus2.out_ready = 1'b1;
    bus2.in_valid = 1'b1;
    bus2.instr = mk(5'd2, 2'b00, 1'b0);
    bus2.rm_val = 32'd9;
    for (int c = 0; c < 10; c++) step();
    bus2.instr = mk(5'd0, 2'b11, 1'b0);
    for (int c = 0; c < 10; c++) step();
    bus2.in_valid = 1'b0;
    step();
    checks++;
    if (cnt_ok2 !== 3'd7 || cnt_err2 !== 3'd7) begin
      errors++;
      $display("FAIL saturate: got ok=%0d err=%0d, want 7 7", cnt_ok2, cnt_err2);
    end
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.instr = mk(5'd5, 2'b10, 1'b0);
    bus.rm_val = 32'h8000_0000;
    step();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.funct !== 2'b11) begin
      errors++;
      $display("FAIL mid_pre: got v=%b f=%b, want 1 11", bus.out_valid, bus.funct);
    end
    rst_n = 1'b0;
    step();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.funct !== 2'b01 || bus.a !== 32'd0 || cnt_ok !== 16'd0 || cnt_err !== 16'd0) begin
      errors++;
      $display("FAIL mid_reset: got v=%b f=%b a=%h ok=%0d err=%0d, want 0 01 0 0 0",
               bus.out_valid, bus.funct, bus.a, cnt_ok, cnt_err);
    end
    rst_n = 1'b1;
    bus.in_valid = 1'b1;
    bus.instr = mk(5'd4, 2'b01, 1'b0);
    bus.rm_val = 32'h100;
    bus.out_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.funct !== 2'b10 || bus.N !== 5'd4 || bus.a !== 32'h100) begin
      errors++;
      $display("FAIL mid_after: got v=%b f=%b N=%0d a=%h, want 1 10 4 100", bus.out_valid, bus.funct, bus.N, bus.a);
    end
    step();
    checks++;
    if (cnt_ok !== 16'd1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_count: got ok=%0d v=%b, want 1 0", cnt_ok, bus.out_valid);
    end
  endtask

  initial begin
    bus2.in_valid = 1'b0;
    bus2.out_ready = 1'b0;
    bus2.instr = 32'd0;
    bus2.rm_val = 32'd0;
    bus2.rs_val = 32'd0;
    test_reset();
    test_decode();
    test_back_to_back();
    test_error_counter();
    test_saturation();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
